// File: rtl/td4_cpu.sv
// rtl/td4_cpu.sv - TD4-class 4-bit CPU with fixed 16x8 program ROM
module td4_cpu (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw,
  output logic [3:0] LED
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] out_reg;
  logic [3:0] pc;
  logic       c;

  logic [7:0] instr;
  logic [3:0] opcode;
  logic [3:0] im;
  logic [3:0] src;
  logic [4:0] sum;

  assign opcode = instr[7:4];
  assign im     = instr[3:0];
  assign LED    = out_reg;

  // Program ROM: counts LED up from the switch value, then shows 5 and halts
  always_comb begin
    instr = 8'h00;
    case (pc)
      4'h0:    instr = 8'h20;
      4'h1:    instr = 8'h40;
      4'h2:    instr = 8'h90;
      4'h3:    instr = 8'h01;
      4'h4:    instr = 8'hE1;
      4'h5:    instr = 8'hB5;
      4'h6:    instr = 8'hF6;
      default: instr = 8'h00;
    endcase
  end

  // Adder source select; immediate-only instructions add to zero so carry clears
  always_comb begin
    src = 4'h0;
    case (opcode)
      4'b0000, 4'b0100:          src = a;
      4'b0101, 4'b0001, 4'b1001: src = b;
      4'b0010, 4'b0110:          src = sw;
      default:                   src = 4'h0;
    endcase
  end

  assign sum = {1'b0, src} + {1'b0, im};

  // Commit one instruction per clock: register write, carry, and PC update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a       <= 4'h0;
      b       <= 4'h0;
      out_reg <= 4'h0;
      pc      <= 4'h0;
      c       <= 1'b0;
    end else begin
      c <= sum[4];
      case (opcode)
        4'b0000, 4'b0011, 4'b0001, 4'b0010: a       <= sum[3:0];
        4'b0101, 4'b0111, 4'b0100, 4'b0110: b       <= sum[3:0];
        4'b1001, 4'b1011:                   out_reg <= sum[3:0];
        default: ;
      endcase
      case (opcode)
        4'b1111: pc <= im;
        4'b1110: pc <= c ? pc + 4'd1 : im;
        default: pc <= pc + 4'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_cpu.sv
// tb/tb_td4_cpu.sv - directed self-checking bench for td4_cpu
`timescale 1ns/1ps
module tb_td4_cpu;

  logic       clock;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] LED;

  int checks;
  int failures;

  td4_cpu dut (
    .clock (clock),
    .reset (reset),
    .sw    (sw),
    .LED   (LED)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sw    = 4'h0;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (LED !== 4'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", LED); end
    checks++;
    if (dut.pc !== 4'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", dut.pc); end
    checks++;
    if (dut.c !== 1'b0) begin failures++; $display("FAIL reset_c got=%b exp=0", dut.c); end
    // run partway, then reset between edges
    release_reset();
    repeat (9) tick();
    checks++;
    if (LED !== 4'h1) begin failures++; $display("FAIL midrun_led got=%h exp=1", LED); end
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (LED !== 4'h0) begin failures++; $display("FAIL midrun_reset_led got=%h exp=0", LED); end
    checks++;
    if (dut.pc !== 4'h0) begin failures++; $display("FAIL midrun_reset_pc got=%h exp=0", dut.pc); end
    sw = 4'h6;
    release_reset();
    tick();
    checks++;
    if (dut.a !== 4'h6) begin failures++; $display("FAIL edge1_a got=%h exp=6", dut.a); end
    tick();
    checks++;
    if (dut.b !== 4'h6 || LED !== 4'h0) begin
      failures++; $display("FAIL edge2_b got=%h led=%h exp b=6 led=0", dut.b, LED);
    end
    tick();
    checks++;
    if (LED !== 4'h6) begin failures++; $display("FAIL edge3_led got=%h exp=6", LED); end
  endtask

  task automatic test_count_sw0();
    logic [3:0] exp;
    int         bad;
    sw    = 4'h0;
    reset = 1'b1;
    tick();
    release_reset();
    bad = 0;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (n < 3)       exp = 4'h0;
      else if (n < 66) exp = 4'((n - 3) / 4);
      else             exp = 4'h5;
      checks++;
      if (LED !== exp) begin
        failures++;
        if (bad < 5) $display("FAIL count_sw0 edge=%0d got=%h exp=%h", n, LED, exp);
        bad++;
      end
      if (n == 64) begin
        checks++;
        if (dut.c !== 1'b1 || dut.a !== 4'h0) begin
          failures++; $display("FAIL wrap_sw0 c=%b a=%h exp c=1 a=0", dut.c, dut.a);
        end
      end
    end
    repeat (130) tick();
    checks++;
    if (LED !== 4'h5 || dut.pc !== 4'h6) begin
      failures++; $display("FAIL halt_edge200 led=%h pc=%h exp led=5 pc=6", LED, dut.pc);
    end
  endtask

  task automatic test_async_reset_halt();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (LED !== 4'h0) begin failures++; $display("FAIL async_led got=%h exp=0", LED); end
    checks++;
    if (dut.pc !== 4'h0) begin failures++; $display("FAIL async_pc got=%h exp=0", dut.pc); end
    sw = 4'h2;
    release_reset();
    repeat (3) tick();
    checks++;
    if (LED !== 4'h2) begin failures++; $display("FAIL restart_e3 got=%h exp=2", LED); end
    repeat (4) tick();
    checks++;
    if (LED !== 4'h3) begin failures++; $display("FAIL restart_e7 got=%h exp=3", LED); end
  endtask

  task automatic test_carry_swd();
    sw    = 4'hD;
    reset = 1'b1;
    tick();
    release_reset();
    repeat (3) tick();
    checks++;
    if (LED !== 4'hD) begin failures++; $display("FAIL swd_e3 got=%h exp=D", LED); end
    repeat (4) tick();
    checks++;
    if (LED !== 4'hE) begin failures++; $display("FAIL swd_e7 got=%h exp=E", LED); end
    repeat (4) tick();
    checks++;
    if (LED !== 4'hF) begin failures++; $display("FAIL swd_e11 got=%h exp=F", LED); end
    tick();
    checks++;
    if (dut.c !== 1'b1 || dut.a !== 4'h0 || dut.pc !== 4'h4) begin
      failures++; $display("FAIL swd_wrap c=%b a=%h pc=%h exp c=1 a=0 pc=4", dut.c, dut.a, dut.pc);
    end
    tick();
    checks++;
    if (dut.pc !== 4'h5 || dut.c !== 1'b0) begin
      failures++; $display("FAIL swd_jnc pc=%h c=%b exp pc=5 c=0", dut.pc, dut.c);
    end
    tick();
    checks++;
    if (dut.pc !== 4'h6 || dut.c !== 1'b0 || LED !== 4'h5) begin
      failures++; $display("FAIL swd_out5 pc=%h c=%b led=%h exp pc=6 c=0 led=5", dut.pc, dut.c, LED);
    end
    repeat (5) tick();
    checks++;
    if (dut.pc !== 4'h6 || LED !== 4'h5) begin
      failures++; $display("FAIL swd_halt pc=%h led=%h exp pc=6 led=5", dut.pc, LED);
    end
  endtask

  task automatic test_sw_ignored();
    sw    = 4'h0;
    reset = 1'b1;
    tick();
    release_reset();
    tick();
    sw = 4'hF;
    tick();
    tick();
    checks++;
    if (LED !== 4'h0) begin failures++; $display("FAIL swign_e3 got=%h exp=0", LED); end
    repeat (4) tick();
    checks++;
    if (LED !== 4'h1) begin failures++; $display("FAIL swign_e7 got=%h exp=1", LED); end
    repeat (4) tick();
    checks++;
    if (LED !== 4'h2) begin failures++; $display("FAIL swign_e11 got=%h exp=2", LED); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    sw       = 4'h0;
    test_reset();
    test_count_sw0();
    test_async_reset_halt();
    test_carry_swd();
    test_sw_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
